// File: rtl/pwm_capture.sv
// PWM duty-cycle recovery: counts high cycles over fixed windows, aligning each window to a
// PWM rising edge when one is seen, and hands results out through a valid/ready register.
module pwm_capture #(
  parameter int unsigned CYCLES_PER_WINDOW = 1024,
  parameter int unsigned CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW),
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwm,
  output logic [CODE_WIDTH-1:0] code,
  output logic                  code_valid,
  input  logic                  code_ready,
  output logic                  locked,
  output logic                  resync,
  output logic                  overrun
);

  localparam int unsigned WinW  = $clog2(CYCLES_PER_WINDOW);
  localparam int unsigned HighW = CODE_WIDTH + 1;
  localparam logic [WinW-1:0]  LastIdx = WinW'(CYCLES_PER_WINDOW - 1);
  localparam logic [HighW-1:0] CodeMax = {1'b0, {CODE_WIDTH{1'b1}}};

  typedef enum logic {StSeek, StMeasure} state_e;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pwm_d;
  state_e                 r_state;
  logic [WinW-1:0]        r_win_cnt;
  logic [HighW-1:0]       r_high_cnt;
  logic [CODE_WIDTH-1:0]  r_code;
  logic                   r_code_valid;
  logic                   r_resync;
  logic                   r_overrun;

  logic                  w_pwm_s;
  logic                  w_rise;
  logic [HighW-1:0]      w_high_total;
  logic [CODE_WIDTH-1:0] w_code_sat;
  logic                  w_publish;
  state_e                w_state_nxt;
  logic [WinW-1:0]       w_win_cnt_nxt;
  logic [HighW-1:0]      w_high_cnt_nxt;
  logic                  w_resync_nxt;
  logic [CODE_WIDTH-1:0] w_code_nxt;
  logic                  w_code_valid_nxt;
  logic                  w_overrun_nxt;

  assign w_pwm_s      = r_sync[SYNC_STAGES-1];
  assign w_rise       = w_pwm_s & ~r_pwm_d;
  // Window total includes the sample of the cycle being processed.
  assign w_high_total = r_high_cnt + {{CODE_WIDTH{1'b0}}, w_pwm_s};
  assign w_code_sat   = (w_high_total > CodeMax) ? CodeMax[CODE_WIDTH-1:0]
                                                 : w_high_total[CODE_WIDTH-1:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_win_cnt_nxt  = r_win_cnt + WinW'(1);
    w_high_cnt_nxt = w_high_total;
    w_publish      = 1'b0;
    w_resync_nxt   = 1'b0;
    case (r_state)
      StSeek: begin
        if (w_rise) begin
          w_state_nxt    = StMeasure;
          w_win_cnt_nxt  = WinW'(1);
          w_high_cnt_nxt = HighW'(1);
        end else if (r_win_cnt == LastIdx) begin
          w_publish      = 1'b1;
          w_win_cnt_nxt  = '0;
          w_high_cnt_nxt = '0;
        end
      end
      StMeasure: begin
        // A rise off index 0 restarts the window and wins over a same-cycle publish.
        if (w_rise && (r_win_cnt != '0)) begin
          w_resync_nxt   = 1'b1;
          w_win_cnt_nxt  = WinW'(1);
          w_high_cnt_nxt = HighW'(1);
        end else if (r_win_cnt == LastIdx) begin
          w_publish      = 1'b1;
          w_win_cnt_nxt  = '0;
          w_high_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = StSeek;
    endcase
  end

  always_comb begin
    w_code_nxt       = r_code;
    w_code_valid_nxt = r_code_valid;
    w_overrun_nxt    = 1'b0;
    if (w_publish) begin
      w_code_nxt       = w_code_sat;
      w_code_valid_nxt = 1'b1;
      w_overrun_nxt    = r_code_valid & ~code_ready;
    end else if (r_code_valid && code_ready) begin
      w_code_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync       <= '0;
      r_pwm_d      <= 1'b0;
      r_state      <= StSeek;
      r_win_cnt    <= '0;
      r_high_cnt   <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_resync     <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], pwm};
      r_pwm_d      <= w_pwm_s;
      r_state      <= w_state_nxt;
      r_win_cnt    <= w_win_cnt_nxt;
      r_high_cnt   <= w_high_cnt_nxt;
      r_code       <= w_code_nxt;
      r_code_valid <= w_code_valid_nxt;
      r_resync     <= w_resync_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign locked     = (r_state == StMeasure);
  assign resync     = r_resync;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed and random PWM patterns against a window/history model that
// sums the synchronised input over each window's span of cycles.
module tb_pwm_capture;

  localparam int Win = 16;
  localparam int CodeMaxV = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm;
  logic [3:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       locked;
  logic       resync;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  // Model state: edge counter since reset release, start edge of current window, outputs.
  int p_hist[$];
  int e, ws, ph;
  int m_locked, m_valid, m_code, m_resync, m_overrun;

  pwm_capture #(
    .CYCLES_PER_WINDOW(16),
    .CODE_WIDTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pwm(pwm),
    .code(code),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .locked(locked),
    .resync(resync),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d: observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  // Synchronised pwm seen at edge k is the pwm driven before edge k-2.
  function automatic int s_at(int k);
    if (k < 2) return 0;
    return p_hist[k-2];
  endfunction

  task automatic model_init();
    p_hist.delete();
    e = 0; ws = 0;
    m_locked = 0; m_valid = 0; m_code = 0; m_resync = 0; m_overrun = 0;
  endtask

  task automatic model_edge(input int p, input int r);
    int rise, idx, pub, sum;
    p_hist.push_back(p);
    rise = (s_at(e) == 1 && s_at(e - 1) == 0) ? 1 : 0;
    idx = e - ws;
    pub = 0; sum = 0;
    m_resync = 0;
    m_overrun = 0;
    if (rise == 1 && (m_locked == 0 || idx != 0)) begin
      m_resync = m_locked;
      m_locked = 1;
      ws = e;
    end else if (idx == Win - 1) begin
      pub = 1;
      for (int k = ws; k <= e; k++) sum += s_at(k);
      ws = e + 1;
    end
    if (pub == 1) begin
      m_overrun = (m_valid == 1 && r == 0) ? 1 : 0;
      m_code = (sum > CodeMaxV) ? CodeMaxV : sum;
      m_valid = 1;
    end else if (m_valid == 1 && r == 1) begin
      m_valid = 0;
    end
    e++;
  endtask

  task automatic step(input logic p, input logic r);
    pwm = p;
    code_ready = r;
    @(posedge clk);
    model_edge(int'(p), int'(r));
    @(negedge clk);
    check("locked", 32'(locked), m_locked);
    check("resync", 32'(resync), m_resync);
    check("overrun", 32'(overrun), m_overrun);
    check("code_valid", 32'(code_valid), m_valid);
    check("code", 32'(code), m_code);
  endtask

  // Ready modes: 0 low, 1 high, 2 random, 3 rare pulses, 4 high only on publishing edges.
  task automatic run_pwm(input int period, input int high, input int n, input int mode);
    logic p, r;
    for (int i = 0; i < n; i++) begin
      p = ((ph % period) < high);
      case (mode)
        0: r = 1'b0;
        1: r = 1'b1;
        2: r = 1'($urandom_range(0, 1));
        3: r = ($urandom_range(0, 7) == 0);
        default: r = ((e - ws) == Win - 1);
      endcase
      step(p, r);
      ph++;
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_code", 32'(code), 0);
    check("rst_code_valid", 32'(code_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_resync", 32'(resync), 0);
    check("rst_overrun", 32'(overrun), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_init();
    ph = 0;
  endtask

  initial begin
    rst = 1'b1;
    pwm = 1'b0;
    code_ready = 1'b0;
    model_init();
    ph = 0;
    #12;
    check("init_code", 32'(code), 0);
    check("init_code_valid", 32'(code_valid), 0);
    check("init_locked", 32'(locked), 0);
    check("init_resync", 32'(resync), 0);
    check("init_overrun", 32'(overrun), 0);
    @(negedge clk);
    rst = 1'b0;

    // Steady 5/16 duty with ready held high.
    run_pwm(16, 5, 100, 1);
    // Reset mid-window, then constant low and constant high levels.
    do_reset();
    run_pwm(16, 0, 50, 1);
    do_reset();
    run_pwm(16, 16, 50, 1);
    // Lock, one short period of 11, then back to 16.
    do_reset();
    run_pwm(16, 5, 48, 1);
    ph = 0;
    run_pwm(11, 5, 11, 1);
    ph = 0;
    run_pwm(16, 5, 48, 1);
    // Unconsumed results: duty 3 then 7 with ready low, then a single ready cycle.
    do_reset();
    run_pwm(16, 3, 32, 0);
    run_pwm(16, 7, 20, 0);
    run_pwm(16, 7, 1, 1);
    run_pwm(16, 7, 4, 0);
    // Handshake landing exactly on publishing edges.
    run_pwm(16, 7, 60, 4);
    run_pwm(16, 9, 40, 3);

    for (int seg = 0; seg < 12; seg++) begin
      int period, high, len, mode;
      if ($urandom_range(0, 3) == 0) do_reset();
      period = $urandom_range(4, 24);
      high = $urandom_range(0, period);
      len = $urandom_range(30, 120);
      mode = $urandom_range(0, 4);
      ph = $urandom_range(0, 30);
      run_pwm(period, high, len, mode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
